// File: rtl/corr_run_ctrl_if.sv
// Host-side command/tick inputs and gate-control outputs of the correlator run controller.
interface corr_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [7:0]       cmd_data;
  logic             cmd_valid;
  logic             sample_tick;
  logic             start;
  logic             stop;
  logic             clr;
  logic             running;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] remaining;

  modport master (
    output cmd_data, cmd_valid, sample_tick,
    input  start, stop, clr, running, done, err, remaining
  );

  modport slave (
    input  cmd_data, cmd_valid, sample_tick,
    output start, stop, clr, running, done, err, remaining
  );
endinterface

// File: rtl/corr_run_ctrl.sv
// Decodes host command bytes into start/stop/clr pulses for the correlator sample gate,
// including timed runs that stop on their own after N sample strobes.
module corr_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  corr_run_ctrl_if.slave  bus
);

  localparam int NBYTES = CNT_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_STOP  = 8'h50;
  localparam logic [7:0] CMD_CLR   = 8'h43;
  localparam logic [7:0] CMD_TIMED = 8'h54;

  typedef enum logic [1:0] {IDLE, RUN, RX_LEN, TIMED_RUN} state_t;

  state_t           state, state_n;
  logic             running, running_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [CNT_W-1:0] shadow, shadow_n;
  logic [IDX_W-1:0] byte_idx, byte_idx_n;
  logic             start_q, stop_q, clr_q, done_q, err_q;
  logic             start_n, stop_n, clr_n, done_n, err_n;
  logic [CNT_W-1:0] len_next;
  logic             tick_live;

  // A tick only counts in TIMED_RUN; any recognised command byte in the same cycle overrides it.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_n     = state;
    running_n   = running;
    remaining_n = remaining;
    shadow_n    = shadow;
    byte_idx_n  = byte_idx;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    clr_n       = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    tick_live   = (state == TIMED_RUN) && bus.sample_tick;

    len_next = shadow;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_idx == IDX_W'(i)) len_next[8*i +: 8] = bus.cmd_data;
    end

    if (state == RX_LEN) begin
      tick_live = 1'b0;
      if (bus.cmd_valid) begin
        shadow_n = len_next;
        if (byte_idx == LAST_IDX) begin
          if (len_next != '0) begin
            start_n     = 1'b1;
            running_n   = 1'b1;
            remaining_n = len_next;
            state_n     = TIMED_RUN;
          end else begin
            err_n       = 1'b1;
            remaining_n = '0;
            state_n     = running ? RUN : IDLE;
          end
        end else begin
          byte_idx_n = byte_idx + IDX_W'(1);
        end
      end
    end else if (bus.cmd_valid) begin
      unique case (bus.cmd_data)
        CMD_START: begin
          tick_live   = 1'b0;
          start_n     = 1'b1;
          running_n   = 1'b1;
          remaining_n = '0;
          state_n     = RUN;
        end
        CMD_STOP: begin
          tick_live   = 1'b0;
          stop_n      = 1'b1;
          running_n   = 1'b0;
          remaining_n = '0;
          state_n     = IDLE;
        end
        CMD_CLR: begin
          tick_live   = 1'b0;
          clr_n       = 1'b1;
          running_n   = 1'b1;
          remaining_n = '0;
          state_n     = RUN;
        end
        CMD_TIMED: begin
          tick_live  = 1'b0;
          byte_idx_n = '0;
          state_n    = RX_LEN;
        end
        default: err_n = 1'b1;
      endcase
    end

    if (tick_live) begin
      if (remaining == CNT_W'(1)) begin
        stop_n      = 1'b1;
        done_n      = 1'b1;
        running_n   = 1'b0;
        remaining_n = '0;
        state_n     = IDLE;
      end else begin
        remaining_n = remaining - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      running   <= 1'b0;
      remaining <= '0;
      shadow    <= '0;
      byte_idx  <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      running   <= running_n;
      remaining <= remaining_n;
      shadow    <= shadow_n;
      byte_idx  <= byte_idx_n;
      start_q   <= start_n;
      stop_q    <= stop_n;
      clr_q     <= clr_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  assign bus.start     = start_q;
  assign bus.stop      = stop_q;
  assign bus.clr       = clr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.running   = running;
  assign bus.remaining = remaining;

endmodule

// File: tb/tb_corr_run_ctrl.sv
// Directed bench for corr_run_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_corr_run_ctrl;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  corr_run_ctrl_if #(.CNT_W(32)) bus ();

  corr_run_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {start, stop, clr, running, done, err}
  function automatic logic [5:0] flags();
    return {bus.start, bus.stop, bus.clr, bus.running, bus.done, bus.err};
  endfunction

  // Drive one byte (optionally with a tick) across one rising edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b, input logic tk = 1'b0);
    bus.cmd_data    = b;
    bus.cmd_valid   = 1'b1;
    bus.sample_tick = tk;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    bus.sample_tick = 1'b0;
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  task automatic send_timed(input logic [31:0] n);
    send(8'h54);
    for (int i = 0; i < 4; i++) send(n[8*i +: 8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_data = '0; bus.cmd_valid = 1'b0; bus.sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (flags() !== 6'b000000 || bus.remaining !== 32'd0) begin
      errors++; $display("FAIL reset_state flags=%b rem=%0d want 000000 rem=0", flags(), bus.remaining);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_stop();
    send(8'h53);
    checks++;
    if (flags() !== 6'b100100) begin errors++; $display("FAIL start_cmd flags=%b want 100100", flags()); end
    @(negedge clk);
    checks++;
    if (flags() !== 6'b000100) begin errors++; $display("FAIL start_one_cycle flags=%b want 000100", flags()); end
    send(8'h50);
    checks++;
    if (flags() !== 6'b010000) begin errors++; $display("FAIL stop_cmd flags=%b want 010000", flags()); end
  endtask

  task automatic test_timed();
    int seen;
    seen = 0;
    send_timed(32'd5);
    checks++;
    if (flags() !== 6'b100100 || bus.remaining !== 32'd5) begin
      errors++; $display("FAIL timed_start flags=%b rem=%0d want 100100 rem=5", flags(), bus.remaining);
    end
    for (int k = 1; k <= 7; k++) begin
      if (bus.running) seen++;
      tick();
      checks++;
      if (k < 5) begin
        if (flags() !== 6'b000100 || bus.remaining !== 32'(5 - k)) begin
          errors++; $display("FAIL timed_tick%0d flags=%b rem=%0d want 000100 rem=%0d", k, flags(), bus.remaining, 5 - k);
        end
      end else if (k == 5) begin
        if (flags() !== 6'b010010 || bus.remaining !== 32'd0) begin
          errors++; $display("FAIL timed_expire flags=%b rem=%0d want 010010 rem=0", flags(), bus.remaining);
        end
      end else begin
        if (flags() !== 6'b000000 || bus.remaining !== 32'd0) begin
          errors++; $display("FAIL timed_after%0d flags=%b rem=%0d want 000000 rem=0", k, flags(), bus.remaining);
        end
      end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (seen !== 5) begin errors++; $display("FAIL timed_tick_count got=%0d want 5", seen); end
  endtask

  task automatic test_zero_len();
    send_timed(32'd0);
    checks++;
    if (flags() !== 6'b000001 || bus.remaining !== 32'd0) begin
      errors++; $display("FAIL zero_len flags=%b rem=%0d want 000001 rem=0", flags(), bus.remaining);
    end
    tick();
    checks++;
    if (flags() !== 6'b000000) begin errors++; $display("FAIL zero_len_idle flags=%b want 000000", flags()); end
  endtask

  task automatic test_cancel();
    logic saw_done;
    saw_done = 1'b0;
    send_timed(32'd5);
    tick(); tick();
    checks++;
    if (bus.remaining !== 32'd3) begin errors++; $display("FAIL cancel_pre rem=%0d want 3", bus.remaining); end
    send(8'h53);
    checks++;
    if (flags() !== 6'b100100 || bus.remaining !== 32'd0) begin
      errors++; $display("FAIL cancel_start flags=%b rem=%0d want 100100 rem=0", flags(), bus.remaining);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.done || bus.stop) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || bus.running !== 1'b1) begin
      errors++; $display("FAIL cancel_untimed done_or_stop=%b running=%b want 0 1", saw_done, bus.running);
    end
    send(8'h50);
  endtask

  task automatic test_unknown_clr();
    send(8'h41);
    checks++;
    if (flags() !== 6'b000001) begin errors++; $display("FAIL unknown_err flags=%b want 000001", flags()); end
    send(8'h43);
    checks++;
    if (flags() !== 6'b001100) begin errors++; $display("FAIL clr_cmd flags=%b want 001100", flags()); end
    send(8'h50);
  endtask

  task automatic test_conflict();
    send_timed(32'd1);
    send(8'h50, 1'b1);
    checks++;
    if (flags() !== 6'b010000 || bus.remaining !== 32'd0) begin
      errors++; $display("FAIL conflict_stop flags=%b rem=%0d want 010000 rem=0", flags(), bus.remaining);
    end
    send_timed(32'd1);
    send(8'h41, 1'b1);
    checks++;
    if (flags() !== 6'b010011) begin errors++; $display("FAIL conflict_unknown flags=%b want 010011", flags()); end
    send_timed(32'd1);
    send(8'h54, 1'b1);
    checks++;
    if (flags() !== 6'b000100 || bus.remaining !== 32'd1) begin
      errors++; $display("FAIL conflict_timed_hold flags=%b rem=%0d want 000100 rem=1", flags(), bus.remaining);
    end
    for (int i = 0; i < 4; i++) send(8'h00);
    checks++;
    if (flags() !== 6'b000101 || bus.remaining !== 32'd0) begin
      errors++; $display("FAIL zero_len_running flags=%b rem=%0d want 000101 rem=0", flags(), bus.remaining);
    end
    send(8'h50);
  endtask

  task automatic test_reset_mid();
    send(8'h53);
    send(8'h54);
    send(8'h07);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (flags() !== 6'b000000 || bus.remaining !== 32'd0) begin
      errors++; $display("FAIL reset_mid flags=%b rem=%0d want 000000 rem=0", flags(), bus.remaining);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h53);
    checks++;
    if (flags() !== 6'b100100) begin errors++; $display("FAIL reset_then_start flags=%b want 100100", flags()); end
    send(8'h50);
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_timed();
    test_zero_len();
    test_cancel();
    test_unknown_clr();
    test_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
